// File: rtl/camera_pkg.sv
// Shared camera-side definitions: sequencer state encoding, COM7 soft-reset
// register location and small compile-time helpers.
package camera_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      DELAY = 3'd5,
      DONE  = 3'd6,
      ERROR = 3'd7
   } seq_state_t;

   localparam logic [7:0] SCCB_COM7_ADDR      = 8'h12;
   localparam int         SCCB_COM7_RESET_BIT = 7;

   // Larger of two integers, used to size counters from parameters.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // True when a register write triggers the sensor's soft reset (COM7 bit 7).
   function automatic logic is_soft_reset(input logic [7:0] addr, input logic [7:0] data);
      return (addr == SCCB_COM7_ADDR) && data[SCCB_COM7_RESET_BIT];
   endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// Loadable down-counter with a zero flag. Load takes priority over
// decrement; the counter holds at zero once it gets there.
module seq_delay_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_r;

   // Counter register: load, count down toward zero, or hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= {WIDTH{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (dec && (count_r != {WIDTH{1'b0}})) begin
         count_r <= count_r - WIDTH'(1'b1);
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/sccb_config_sequencer.sv
// Camera register init sequencer: reads each {reg_addr, reg_data} entry from
// the registered init ROM, hands it to the SCCB write master, waits for the
// transfer result, retries NACKed writes and inserts settle delays.
module sccb_config_sequencer
   import camera_pkg::*;
#(
   parameter int NUM_ENTRIES = 79,
   parameter int RESET_DELAY = 50000,
   parameter int GAP_CYCLES  = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  rom_address,
   input  logic [15:0] rom_register,
   output logic        sccb_valid,
   input  logic        sccb_ready,
   output logic [7:0]  sccb_reg_addr,
   output logic [7:0]  sccb_reg_data,
   input  logic        sccb_done,
   input  logic        sccb_nack,
   output logic        busy,
   output logic        config_done,
   output logic        config_error,
   output logic [7:0]  err_index
);

   localparam int DELAY_MAX = max_int(RESET_DELAY, GAP_CYCLES);
   localparam int DW        = (DELAY_MAX > 0) ? $clog2(DELAY_MAX + 1) : 1;
   localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [7:0]    LAST_IDX    = 8'(NUM_ENTRIES - 1);
   localparam logic [DW-1:0] RESET_LOAD  = DW'(RESET_DELAY);
   localparam logic [DW-1:0] GAP_LOAD    = DW'(GAP_CYCLES);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   seq_state_t    state_r;
   seq_state_t    state_nxt_s;

   logic [7:0]    idx_r;
   logic [7:0]    idx_nxt_s;
   logic [RW-1:0] retry_r;
   logic [RW-1:0] retry_nxt_s;
   logic [7:0]    cmd_addr_r;
   logic [7:0]    cmd_addr_nxt_s;
   logic [7:0]    cmd_data_r;
   logic [7:0]    cmd_data_nxt_s;
   logic          valid_r;
   logic          valid_nxt_s;
   logic          busy_r;
   logic          busy_nxt_s;
   logic          done_r;
   logic          done_nxt_s;
   logic          error_r;
   logic          error_nxt_s;
   logic [7:0]    err_index_r;
   logic [7:0]    err_index_nxt_s;

   logic          timer_load_s;
   logic          timer_dec_s;
   logic          timer_zero_s;
   logic [DW-1:0] timer_value_s;

   // A COM7 soft reset needs the long settle time; everything else gets the gap.
   assign timer_value_s = is_soft_reset(cmd_addr_r, cmd_data_r) ? RESET_LOAD : GAP_LOAD;

   seq_delay_timer #(
      .WIDTH(DW)
   ) u_delay (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load_s),
      .load_value (timer_value_s),
      .dec        (timer_dec_s),
      .zero       (timer_zero_s)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = state_r;
            end
         end
         FETCH: state_nxt_s = LATCH;
         LATCH: state_nxt_s = ISSUE;
         ISSUE: begin
            if (valid_r && sccb_ready) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         WAIT: begin
            if (sccb_done && !sccb_nack) begin
               state_nxt_s = DELAY;
            end else if (sccb_done && (retry_r < RETRY_LIMIT)) begin
               state_nxt_s = ISSUE;
            end else if (sccb_done) begin
               state_nxt_s = ERROR;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         DELAY: begin
            if (timer_zero_s && (idx_r == LAST_IDX)) begin
               state_nxt_s = DONE;
            end else if (timer_zero_s) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = DELAY;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output / datapath next-value decode; everything is registered below.
   always_comb begin
      idx_nxt_s       = idx_r;
      retry_nxt_s     = retry_r;
      cmd_addr_nxt_s  = cmd_addr_r;
      cmd_data_nxt_s  = cmd_data_r;
      done_nxt_s      = done_r;
      error_nxt_s     = error_r;
      err_index_nxt_s = err_index_r;
      timer_load_s    = 1'b0;
      timer_dec_s     = 1'b0;
      case (state_r)
         IDLE, DONE, ERROR: begin
            if (start) begin
               idx_nxt_s       = 8'h00;
               retry_nxt_s     = {RW{1'b0}};
               done_nxt_s      = 1'b0;
               error_nxt_s     = 1'b0;
               err_index_nxt_s = 8'h00;
            end else begin
               idx_nxt_s       = idx_r;
            end
         end
         LATCH: begin
            cmd_addr_nxt_s = rom_register[15:8];
            cmd_data_nxt_s = rom_register[7:0];
         end
         WAIT: begin
            if (sccb_done && !sccb_nack) begin
               retry_nxt_s  = {RW{1'b0}};
               timer_load_s = 1'b1;
            end else if (sccb_done && (retry_r < RETRY_LIMIT)) begin
               retry_nxt_s  = retry_r + RW'(1'b1);
            end else if (sccb_done) begin
               error_nxt_s     = 1'b1;
               err_index_nxt_s = idx_r;
            end else begin
               retry_nxt_s  = retry_r;
            end
         end
         DELAY: begin
            timer_dec_s = 1'b1;
            // The last-entry compare comes first so idx never wraps past 255.
            if (timer_zero_s && (idx_r == LAST_IDX)) begin
               done_nxt_s = 1'b1;
            end else if (timer_zero_s) begin
               idx_nxt_s  = idx_r + 8'd1;
            end else begin
               idx_nxt_s  = idx_r;
            end
         end
         default: begin
            idx_nxt_s = idx_r;
         end
      endcase
      valid_nxt_s = (state_nxt_s == ISSUE);
      busy_nxt_s  = (state_nxt_s inside {FETCH, LATCH, ISSUE, WAIT, DELAY});
   end

   // Datapath and output registers; reset clears every output at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_r       <= 8'h00;
         retry_r     <= {RW{1'b0}};
         cmd_addr_r  <= 8'h00;
         cmd_data_r  <= 8'h00;
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         err_index_r <= 8'h00;
      end else begin
         idx_r       <= idx_nxt_s;
         retry_r     <= retry_nxt_s;
         cmd_addr_r  <= cmd_addr_nxt_s;
         cmd_data_r  <= cmd_data_nxt_s;
         valid_r     <= valid_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         error_r     <= error_nxt_s;
         err_index_r <= err_index_nxt_s;
      end
   end

   assign rom_address   = idx_r;
   assign sccb_valid    = valid_r;
   assign sccb_reg_addr = cmd_addr_r;
   assign sccb_reg_data = cmd_data_r;
   assign busy          = busy_r;
   assign config_done   = done_r;
   assign config_error  = error_r;
   assign err_index     = err_index_r;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Self-checking bench for sccb_config_sequencer: a 4-entry instance with a
// reactive SCCB master model and scoreboard, plus a 79-entry instance.
module tb_sccb_config_sequencer;

   localparam int NE   = 4;
   localparam int RD   = 40;
   localparam int GAP  = 2;
   localparam int MR   = 3;
   localparam int XFER = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // 4-entry instance
   logic        start, sccb_ready, sccb_done, sccb_nack;
   logic [7:0]  rom_address, sccb_reg_addr, sccb_reg_data, err_index;
   logic [15:0] rom_register;
   logic        sccb_valid, busy, config_done, config_error;

   // 79-entry instance
   logic        start79, ready79, done79_in, nack79;
   logic [7:0]  rom_address79, reg_addr79, reg_data79, err_index79;
   logic [15:0] rom_register79;
   logic        valid79, busy79, done79, error79;

   sccb_config_sequencer #(
      .NUM_ENTRIES(NE), .RESET_DELAY(RD), .GAP_CYCLES(GAP), .MAX_RETRY(MR)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .rom_address(rom_address), .rom_register(rom_register),
      .sccb_valid(sccb_valid), .sccb_ready(sccb_ready),
      .sccb_reg_addr(sccb_reg_addr), .sccb_reg_data(sccb_reg_data),
      .sccb_done(sccb_done), .sccb_nack(sccb_nack),
      .busy(busy), .config_done(config_done), .config_error(config_error),
      .err_index(err_index)
   );

   sccb_config_sequencer #(
      .NUM_ENTRIES(79), .RESET_DELAY(RD), .GAP_CYCLES(GAP), .MAX_RETRY(MR)
   ) dut79 (
      .clock(clock), .reset(reset), .start(start79),
      .rom_address(rom_address79), .rom_register(rom_register79),
      .sccb_valid(valid79), .sccb_ready(ready79),
      .sccb_reg_addr(reg_addr79), .sccb_reg_data(reg_data79),
      .sccb_done(done79_in), .sccb_nack(nack79),
      .busy(busy79), .config_done(done79), .config_error(error79),
      .err_index(err_index79)
   );

   // ROM models: registered read, data one clock after the address
   logic [15:0] rom4 [0:3] = '{16'h1280, 16'h1204, 16'h1180, 16'h0C00};
   logic [15:0] rom79 [0:255];
   always @(posedge clock) rom_register   <= rom4[rom_address[1:0]];
   always @(posedge clock) rom_register79 <= rom79[rom_address79];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard and master-model state
   logic [15:0] exp_q[$];
   logic [15:0] q79[$];
   int          n_writes = 0;
   int          pend = 0;
   logic [15:0] pend_cmd = 16'h0000;
   logic [15:0] nack_key = 16'h0000;
   int          nack_left = 0;
   int          stall_cnt = 0, stall_cycles = 0, stall_drop = 0;
   bit          stall_seen = 1'b0;
   logic [15:0] stall_first = 16'h0000;
   int          cyc = 0, t_done = 0;
   bit          gap_armed = 1'b0;
   int          gaps[$];
   int          n79 = 0, pend79 = 0, zero79 = 0;

   // SCCB master model for the 4-entry instance (acts on the falling edge)
   initial begin
      sccb_ready = 1'b1; sccb_done = 1'b0; sccb_nack = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         sccb_done = 1'b0;
         sccb_nack = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               sccb_done = 1'b1;
               if (pend_cmd == nack_key && nack_left > 0) begin
                  sccb_nack = 1'b1;
                  nack_left--;
               end
               t_done = cyc;
               gap_armed = 1'b1;
            end
         end
         if (sccb_valid && gap_armed) begin
            gaps.push_back(cyc - t_done);
            gap_armed = 1'b0;
         end
         if (sccb_valid && stall_cnt > 0) begin
            sccb_ready = 1'b0;
            stall_cycles++;
            stall_cnt--;
            if (!stall_seen) begin
               stall_first = {sccb_reg_addr, sccb_reg_data};
               stall_seen = 1'b1;
            end else begin
               chk("stall_hold", {sccb_reg_addr, sccb_reg_data}, stall_first);
            end
         end else begin
            if (!sccb_valid && stall_seen && stall_cnt > 0) stall_drop++;
            sccb_ready = 1'b1;
            if (sccb_valid) begin
               n_writes++;
               if (exp_q.size() == 0) chk("extra_write", {16'h0000, sccb_reg_addr, sccb_reg_data}, 32'h0001_0000);
               else chk("write", {sccb_reg_addr, sccb_reg_data}, exp_q.pop_front());
               pend = XFER;
               pend_cmd = {sccb_reg_addr, sccb_reg_data};
            end
         end
      end
   end

   // Always-ready ACKing master for the 79-entry instance
   initial begin
      ready79 = 1'b1; done79_in = 1'b0; nack79 = 1'b0;
      forever begin
         @(negedge clock);
         done79_in = 1'b0;
         if (pend79 > 0) begin
            pend79--;
            if (pend79 == 0) done79_in = 1'b1;
         end
         if (valid79) begin
            n79++;
            if ({reg_addr79, reg_data79} == 16'h0000) zero79++;
            if (q79.size() == 0) chk("extra_write79", {16'h0000, reg_addr79, reg_data79}, 32'h0001_0000);
            else chk("write79", {reg_addr79, reg_data79}, q79.pop_front());
            pend79 = 2;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] nkey;
      int          ncount;
      logic        exp_done;
      logic        exp_err;
      logic [7:0]  exp_eidx;
   } vec_t;
   vec_t tbl [4];

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk(name, busy, 1'b0);
   endtask

   task automatic wait_writes(input int target, input string name);
      int n = 0;
      while (n_writes < target && n < 500) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk(name, n_writes, target);
   endtask

   task automatic push4();
      for (int e = 0; e < NE; e++) exp_q.push_back(rom4[e]);
   endtask

   initial begin
      int w0;
      int n;
      tbl[0] = '{nkey:16'h1180, ncount:0, exp_done:1'b1, exp_err:1'b0, exp_eidx:8'd0};
      tbl[1] = '{nkey:16'h1180, ncount:2, exp_done:1'b1, exp_err:1'b0, exp_eidx:8'd0};
      tbl[2] = '{nkey:16'h1204, ncount:4, exp_done:1'b0, exp_err:1'b1, exp_eidx:8'd1};
      tbl[3] = '{nkey:16'h1180, ncount:0, exp_done:1'b1, exp_err:1'b0, exp_eidx:8'd0};
      for (int i = 0; i < 256; i++) rom79[i] = {8'(i + 1), 8'(i ^ 8'h5A)};
      rom79[60] = 16'h0000;

      reset = 1'b1; start = 1'b0; start79 = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", config_done, 1'b0);
      chk("rst_error", config_error, 1'b0);
      chk("rst_err_index", err_index, 8'h00);
      chk("rst_valid", sccb_valid, 1'b0);
      chk("rst_rom_address", rom_address, 8'h00);
      chk("rst_reg", {sccb_reg_addr, sccb_reg_data}, 16'h0000);
      chk("rst_busy79", busy79, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      #1;

      // table-driven sequences: nack pattern in, final status out
      for (int i = 0; i < 4; i++) begin
         nack_key = tbl[i].nkey;
         nack_left = tbl[i].ncount;
         gaps.delete();
         gap_armed = 1'b0;
         for (int e = 0; e < NE; e++) begin
            int reps;
            bit hit;
            hit = (rom4[e] == tbl[i].nkey) && (tbl[i].ncount > 0);
            reps = !hit ? 1 : ((tbl[i].ncount > MR) ? MR + 1 : tbl[i].ncount + 1);
            for (int r = 0; r < reps; r++) exp_q.push_back(rom4[e]);
            if (hit && tbl[i].ncount > MR) break;
         end
         pulse_start();
         chk("busy_after_start", busy, 1'b1);
         wait_idle("seq_idle");
         repeat (RD + 10) @(negedge clock);
         chk("seq_done", config_done, tbl[i].exp_done);
         chk("seq_error", config_error, tbl[i].exp_err);
         chk("seq_err_index", err_index, tbl[i].exp_eidx);
         chk("seq_missing_writes", exp_q.size(), 0);
         if (i == 0) begin
            chk("gap_after_soft_reset", gaps[0], RD + 4);
            chk("gap_after_12_04", gaps[1], GAP + 4);
            chk("gap_after_11_80", gaps[2], GAP + 4);
         end
      end

      // ready held low for 10 cycles on the first command
      stall_cnt = 10; stall_cycles = 0; stall_drop = 0; stall_seen = 1'b0;
      push4();
      pulse_start();
      wait_idle("stall_idle");
      chk("stall_cycles", stall_cycles, 10);
      chk("stall_valid_drop", stall_drop, 0);
      chk("stall_done", config_done, 1'b1);
      chk("stall_missing_writes", exp_q.size(), 0);

      // start during the soft-reset delay is ignored
      push4();
      w0 = n_writes;
      pulse_start();
      wait_writes(w0 + 1, "delay_first_write");
      repeat (XFER + 6) @(negedge clock);
      #1;
      pulse_start();
      chk("delay_still_busy", busy, 1'b1);
      wait_idle("delay_idle");
      chk("delay_write_count", n_writes - w0, NE);
      chk("delay_done", config_done, 1'b1);
      chk("delay_missing_writes", exp_q.size(), 0);

      // async reset while waiting for the transfer result
      push4();
      w0 = n_writes;
      pulse_start();
      wait_writes(w0 + 1, "rstwait_first_write");
      @(negedge clock);
      #1;
      chk("rstwait_busy_before", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk("rstwait_busy", busy, 1'b0);
      chk("rstwait_valid", sccb_valid, 1'b0);
      chk("rstwait_reg", {sccb_reg_addr, sccb_reg_data}, 16'h0000);
      chk("rstwait_rom_address", rom_address, 8'h00);
      chk("rstwait_done", config_done, 1'b0);
      pend = 0;
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      #1;
      push4();
      pulse_start();
      wait_idle("rstwait_idle");
      chk("rstwait_restart_done", config_done, 1'b1);
      chk("rstwait_missing_writes", exp_q.size(), 0);

      // full 79-entry ROM
      for (int e = 0; e < 79; e++) q79.push_back(rom79[e]);
      start79 = 1'b1;
      @(negedge clock);
      start79 = 1'b0;
      n = 0;
      while (busy79 && n < 5000) begin
         @(negedge clock);
         n++;
      end
      chk("full_busy", busy79, 1'b0);
      chk("full_done", done79, 1'b1);
      chk("full_error", error79, 1'b0);
      chk("full_write_count", n79, 79);
      chk("full_zero_entry", zero79, 1);
      chk("full_last_idx", rom_address79, 8'd78);
      chk("full_missing_writes", q79.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
